instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/y86_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_len_decode.sv | 47 ++++
 rtl/instr_fetch.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the instruction fetch slice.
// Holds the icode values (HALT..POPQ), the "no register" code used for absent
// rA/rB fields, and the fetch FSM state encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of all handshake/bus signals around the fetch unit.
//   PC side   : pc_valid, pc_addr (in), pc_ready (out)
//   Memory    : mem_req, mem_addr (out), mem_ready, mem_rdata, mem_err (in)
//   Decode    : inst_valid, icode, ifun, rA, rB, valC, valP,
//               imem_error, instr_invalid (out), inst_ready (in)
// master = the fetch unit, slave = its environment.
interface instr_fetch_if;
    logic        pc_valid;
    logic [63:0] pc_addr;
    logic        pc_ready;

    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        mem_err;

    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        imem_error;
    logic        instr_invalid;

    modport master (
        input  pc_valid, pc_addr, mem_ready, mem_rdata, mem_err, inst_ready,
        output pc_ready, mem_req, mem_addr, inst_valid, icode, ifun, rA, rB,
               valC, valP, imem_error, instr_invalid
    );

    modport slave (
        output pc_valid, pc_addr, mem_ready, mem_rdata, mem_err, inst_ready,
        input  pc_ready, mem_req, mem_addr, inst_valid, icode, ifun, rA, rB,
               valC, valP, imem_error, instr_invalid
    );

endinterface

// File: rtl/instr_len_decode.sv
// Combinational icode classifier.
//   icode_i       : instruction code (upper nibble of byte 0)
//   need_regids_o : instruction carries a register-specifier byte
//   need_valc_o   : instruction carries an 8-byte constant
//   length_o      : total instruction length in bytes (1..10)
//   invalid_o     : icode outside HALT..POPQ
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       need_regids_o,
    output logic       need_valc_o,
    output logic [3:0] length_o,
    output logic       invalid_o
);

    // Length/field classification table; unknown codes are 1-byte invalid.
    always_comb begin
        need_regids_o = 1'b0;
        need_valc_o   = 1'b0;
        length_o      = 4'd1;
        invalid_o     = 1'b0;
        case (icode_i)
            I_HALT, I_NOP, I_RET: begin
                length_o = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                need_regids_o = 1'b1;
                length_o      = 4'd2;
            end
            I_JXX, I_CALL: begin
                need_valc_o = 1'b1;
                length_o    = 4'd9;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids_o = 1'b1;
                need_valc_o   = 1'b1;
                length_o      = 4'd10;
            end
            default: begin
                invalid_o = 1'b1;
                length_o  = 4'd1;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Y86-64 byte-serial instruction fetch.
// Accepts a PC, reads the instruction one byte per memory handshake, splits it
// into icode/ifun/rA/rB/valC, computes valP and presents the result until the
// decode stage takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_if.master (PC, memory and decode handshakes)
module instr_fetch
    import y86_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [63:0]  base_q, base_d;
    logic [3:0]   count_q, count_d;
    logic [3:0]   icode_q, icode_d;
    logic [3:0]   ifun_q, ifun_d;
    logic [3:0]   ra_q, ra_d;
    logic [3:0]   rb_q, rb_d;
    logic [63:0]  valc_q, valc_d;
    logic [63:0]  valp_q, valp_d;
    logic         imem_error_q, imem_error_d;
    logic         instr_invalid_q, instr_invalid_d;

    logic [3:0]   dec_icode_s;
    logic         need_regids_s;
    logic         need_valc_s;
    logic [3:0]   length_s;
    logic         invalid_s;
    logic [63:0]  fetch_addr_s;
    logic [3:0]   valc_start_s;
    logic [2:0]   valc_idx_s;

    // Byte 0 is decoded straight off the bus; later bytes use the latched icode.
    assign dec_icode_s  = (count_q == 4'd0) ? bus.mem_rdata[7:4] : icode_q;
    assign fetch_addr_s = base_q + {60'd0, count_q};
    assign valc_start_s = need_regids_s ? 4'd2 : 4'd1;
    assign valc_idx_s   = 3'(count_q - valc_start_s);

    instr_len_decode u_len_decode (
        .icode_i       (dec_icode_s),
        .need_regids_o (need_regids_s),
        .need_valc_o   (need_valc_s),
        .length_o      (length_s),
        .invalid_o     (invalid_s)
    );

    // Next-state and field-assembly logic for the IDLE/FETCH/DONE machine.
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        count_d         = count_q;
        icode_d         = icode_q;
        ifun_d          = ifun_q;
        ra_d            = ra_q;
        rb_d            = rb_q;
        valc_d          = valc_q;
        valp_d          = valp_q;
        imem_error_d    = imem_error_q;
        instr_invalid_d = instr_invalid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.pc_valid) begin
                    state_d         = S_FETCH;
                    base_d          = bus.pc_addr;
                    count_d         = 4'd0;
                    icode_d         = 4'h0;
                    ifun_d          = 4'h0;
                    ra_d            = R_NONE;
                    rb_d            = R_NONE;
                    valc_d          = 64'd0;
                    valp_d          = 64'd0;
                    imem_error_d    = 1'b0;
                    instr_invalid_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready && bus.mem_err) begin
                    // Faulted read: the byte is dropped and a NOP-like result is reported.
                    state_d         = S_DONE;
                    imem_error_d    = 1'b1;
                    icode_d         = I_NOP;
                    ifun_d          = 4'h0;
                    ra_d            = R_NONE;
                    rb_d            = R_NONE;
                    valc_d          = 64'd0;
                    instr_invalid_d = 1'b0;
                    valp_d          = fetch_addr_s;
                end else if (bus.mem_ready) begin
                    count_d = count_q + 4'd1;
                    if (count_q == 4'd0) begin
                        icode_d         = bus.mem_rdata[7:4];
                        ifun_d          = bus.mem_rdata[3:0];
                        instr_invalid_d = invalid_s;
                    end else if (need_regids_s && (count_q == 4'd1)) begin
                        ra_d = bus.mem_rdata[7:4];
                        rb_d = bus.mem_rdata[3:0];
                    end else if (need_valc_s && (count_q >= valc_start_s)) begin
                        valc_d[{valc_idx_s, 3'b000} +: 8] = bus.mem_rdata;
                    end else begin
                        valc_d = valc_q;
                    end
                    if (count_d == length_s) begin
                        state_d = S_DONE;
                        valp_d  = base_q + {60'd0, length_s};
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                if (bus.inst_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            base_q          <= 64'd0;
            count_q         <= 4'd0;
            icode_q         <= 4'h0;
            ifun_q          <= 4'h0;
            ra_q            <= R_NONE;
            rb_q            <= R_NONE;
            valc_q          <= 64'd0;
            valp_q          <= 64'd0;
            imem_error_q    <= 1'b0;
            instr_invalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            count_q         <= count_d;
            icode_q         <= icode_d;
            ifun_q          <= ifun_d;
            ra_q            <= ra_d;
            rb_q            <= rb_d;
            valc_q          <= valc_d;
            valp_q          <= valp_d;
            imem_error_q    <= imem_error_d;
            instr_invalid_q <= instr_invalid_d;
        end
    end

    assign bus.pc_ready      = (state_q == S_IDLE);
    assign bus.mem_req       = (state_q == S_FETCH);
    assign bus.mem_addr      = fetch_addr_s;
    assign bus.inst_valid    = (state_q == S_DONE);
    assign bus.icode         = icode_q;
    assign bus.ifun          = ifun_q;
    assign bus.rA            = ra_q;
    assign bus.rB            = rb_q;
    assign bus.valC          = valc_q;
    assign bus.valP          = valp_q;
    assign bus.imem_error    = imem_error_q;
    assign bus.instr_invalid = instr_invalid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// instructions, all compared against a byte-level reference model.
module tb_instr_fetch;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scenario description consumed by run_instr.
    logic [7:0] prog[$];
    int         err_at;
    int         stall_mode;
    int         hold_cycles;

    // Reference model results.
    logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
    logic [63:0] m_valc, m_valp;
    logic        m_err, m_inv;
    int          m_reads;

    localparam logic [212:0] RESET_VEC = {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0,
                                          4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};

    // Expected decode of prog[] at address base, computed from the ISA rules.
    task automatic model(input logic [63:0] base);
        logic [7:0] b0, b1;
        int len, vstart;
        logic need_r, need_c;
        b0 = prog[0];
        b1 = prog[1];
        need_r = 1'b0; need_c = 1'b0; m_inv = 1'b0;
        case (b0[7:4])
            4'h0, 4'h1, 4'h9:         len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: begin len = 2; need_r = 1'b1; end
            4'h7, 4'h8:         begin len = 9; need_c = 1'b1; end
            4'h3, 4'h4, 4'h5:   begin len = 10; need_r = 1'b1; need_c = 1'b1; end
            default:            begin len = 1; m_inv = 1'b1; end
        endcase
        m_icode = b0[7:4];
        m_ifun  = b0[3:0];
        m_ra    = need_r ? b1[7:4] : 4'hF;
        m_rb    = need_r ? b1[3:0] : 4'hF;
        m_valc  = 64'd0;
        vstart  = need_r ? 2 : 1;
        if (need_c) begin
            for (int i = 7; i >= 0; i--) m_valc = (m_valc << 8) | {56'd0, prog[vstart + i]};
        end
        m_valp  = base + 64'(len);
        m_err   = 1'b0;
        m_reads = len;
        if (err_at >= 0 && err_at < len) begin
            m_err   = 1'b1;
            m_icode = 4'h1;
            m_ifun  = 4'h0;
            m_valp  = base + 64'(err_at);
            m_reads = err_at + 1;
        end
    endtask

    // Issue one PC, serve the byte reads, then check the presented instruction.
    task automatic run_instr(input string name, input logic [63:0] base);
        int reads, cycles;
        logic done, rdy;
        model(base);
        @(negedge clk);
        n_cmp++;
        if (bus.pc_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s pc_ready_idle: got %b want 1", name, bus.pc_ready);
        end
        bus.pc_valid = 1'b1;
        bus.pc_addr  = base;
        reads = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < 300) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) begin
                done = 1'b1;
            end else if (bus.mem_req !== 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL %s mem_req: got %b want 1 at read %0d", name, bus.mem_req, reads);
                cycles = 300;
            end else begin
                cycles++;
                n_cmp++;
                if (bus.mem_addr !== base + 64'(reads)) begin
                    n_bad++;
                    $display("FAIL %s mem_addr: got %h want %h", name, bus.mem_addr, base + 64'(reads));
                end
                case (stall_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cycles % 2) == 1;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.mem_ready = rdy;
                bus.mem_rdata = (reads < prog.size()) ? prog[reads] : 8'($urandom);
                bus.mem_err   = (reads == err_at);
                bus.pc_valid  = 1'($urandom_range(0, 1));
                bus.pc_addr   = {$urandom, $urandom};
                if (rdy) reads++;
            end
        end
        bus.mem_ready = 1'b0;
        bus.mem_err   = 1'b0;
        bus.pc_valid  = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL %s inst_valid_timeout: got 0 want 1", name);
        end
        n_cmp++;
        if (reads != m_reads) begin
            n_bad++; $display("FAIL %s read_count: got %0d want %0d", name, reads, m_reads);
        end
        if (stall_mode == 0) begin
            n_cmp++;
            if (cycles != m_reads) begin
                n_bad++; $display("FAIL %s latency: got %0d want %0d", name, cycles, m_reads);
            end
        end
        bus.inst_ready = 1'b0;
        for (int h = 0; h <= hold_cycles; h++) begin
            if (h > 0) begin
                bus.pc_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            n_cmp++;
            if (bus.inst_valid !== 1'b1) begin
                n_bad++; $display("FAIL %s inst_valid[%0d]: got %b want 1", name, h, bus.inst_valid);
            end
            n_cmp++;
            if ({bus.icode, bus.ifun} !== {m_icode, m_ifun}) begin
                n_bad++; $display("FAIL %s icode_ifun[%0d]: got %h want %h", name, h, {bus.icode, bus.ifun}, {m_icode, m_ifun});
            end
            n_cmp++;
            if (bus.valP !== m_valp) begin
                n_bad++; $display("FAIL %s valP[%0d]: got %h want %h", name, h, bus.valP, m_valp);
            end
            n_cmp++;
            if (bus.imem_error !== m_err) begin
                n_bad++; $display("FAIL %s imem_error[%0d]: got %b want %b", name, h, bus.imem_error, m_err);
            end
            if (!m_err) begin
                n_cmp++;
                if ({bus.rA, bus.rB} !== {m_ra, m_rb}) begin
                    n_bad++; $display("FAIL %s rA_rB[%0d]: got %h want %h", name, h, {bus.rA, bus.rB}, {m_ra, m_rb});
                end
                n_cmp++;
                if (bus.valC !== m_valc) begin
                    n_bad++; $display("FAIL %s valC[%0d]: got %h want %h", name, h, bus.valC, m_valc);
                end
                n_cmp++;
                if (bus.instr_invalid !== m_inv) begin
                    n_bad++; $display("FAIL %s instr_invalid[%0d]: got %b want %b", name, h, bus.instr_invalid, m_inv);
                end
            end
        end
        // Release with a new PC already offered: it must not be taken in this cycle.
        bus.inst_ready = 1'b1;
        bus.pc_valid   = 1'b1;
        bus.pc_addr    = {$urandom, $urandom};
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.pc_valid   = 1'b0;
        n_cmp++;
        if ({bus.pc_ready, bus.inst_valid, bus.mem_req} !== 3'b100) begin
            n_bad++;
            $display("FAIL %s release: got ready/valid/req %b want 100", name, {bus.pc_ready, bus.inst_valid, bus.mem_req});
        end
    endtask

    task automatic test_reset();
        logic [212:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {bus.pc_ready, bus.mem_req, bus.mem_addr, bus.inst_valid, bus.imem_error, bus.instr_invalid,
               bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP};
        n_cmp++;
        if (got !== RESET_VEC) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", got, RESET_VEC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        prog = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        err_at = -1; stall_mode = 0; hold_cycles = 0;
        run_instr("irmovq", 64'h100);
        n_cmp++;
        if (bus.valC !== 64'h0102030405060708 || bus.valP !== 64'h10A) begin
            n_bad++; $display("FAIL irmovq_const: got valC %h valP %h want 0102030405060708 10a", bus.valC, bus.valP);
        end
    endtask

    task automatic test_jxx_stall();
        prog = '{8'h73, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        err_at = -1; stall_mode = 1; hold_cycles = 2;
        run_instr("jxx_stall", 64'h2000);
    endtask

    task automatic test_ret_invalid();
        prog = '{8'h90};
        err_at = -1; stall_mode = 0; hold_cycles = 0;
        run_instr("ret", 64'h300);
        prog = '{8'hE0};
        run_instr("invalid", 64'h301);
    endtask

    task automatic test_wrap();
        prog = '{8'h60, 8'h12};
        err_at = -1; stall_mode = 0; hold_cycles = 0;
        run_instr("wrap", 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_mem_err();
        prog = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        err_at = 2; stall_mode = 0; hold_cycles = 5;
        run_instr("mem_err", 64'h5000);
    endtask

    task automatic test_reset_mid_fetch();
        logic [212:0] got;
        @(negedge clk);
        bus.pc_valid = 1'b1; bus.pc_addr = 64'h4000;
        @(negedge clk);
        bus.pc_valid = 1'b0; bus.mem_ready = 1'b1; bus.mem_err = 1'b0; bus.mem_rdata = 8'h30;
        @(negedge clk);
        bus.mem_rdata = 8'hF3;
        @(negedge clk);
        bus.mem_rdata = 8'h11;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {bus.pc_ready, bus.mem_req, bus.mem_addr, bus.inst_valid, bus.imem_error, bus.instr_invalid,
               bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP};
        n_cmp++;
        if (got !== RESET_VEC) begin
            n_bad++; $display("FAIL mid_fetch_reset: got %h want %h", got, RESET_VEC);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.mem_rdata = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({bus.pc_ready, bus.inst_valid, bus.mem_req} !== 3'b100) begin
                n_bad++; $display("FAIL after_reset[%0d]: got ready/valid/req %b want 100", i, {bus.pc_ready, bus.inst_valid, bus.mem_req});
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] base;
        for (int n = 0; n < 24; n++) begin
            prog = {};
            for (int i = 0; i < 10; i++) prog.push_back(8'($urandom));
            err_at      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
            stall_mode  = 2;
            hold_cycles = int'($urandom_range(0, 3));
            base = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                               : {$urandom, $urandom};
            run_instr("random", base);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.pc_valid   = 1'b0;
        bus.pc_addr    = 64'd0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 8'h00;
        bus.mem_err    = 1'b0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_irmovq();
        test_jxx_stall();
        test_ret_invalid();
        test_wrap();
        test_mem_err();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
